sweep_controller: RTL
=====================

// Module: sweep_controller
// PURPOSE
//  Frequency-sweep sequencer for the DDS phase accumulator. Drives the accumulator's
//  phinc input through a programmed ramp (start -> stop in fixed steps, each held for
//  a programmable dwell), single-shot or continuous. Sits between control logic and
//  the accumulator; accumulator phase output is untouched.
// PARAMETERS
//  W   8   phase-increment width (matches accumulator phinc)
//  DW  16  dwell counter width
// PORTS
//  clk         in   1   system clock, rising edge
//  clrn        in   1   asynchronous active-low reset
//  start       in   1   begin sweep (sampled in IDLE only)
//  abort       in   1   stop sweep immediately
//  continuous  in   1   1 = repeat sweep indefinitely
//  f_start     in   W   first increment
//  f_stop      in   W   final increment
//  f_step      in   W   step magnitude (0 treated as 1)
//  dwell       in   DW  extra cycles per value (value held dwell+1 cycles)
//  phinc       out  W   increment to accumulator (registered)
//  busy        out  1   sweep in progress
//  done        out  1   1-cycle pulse at end of single-shot sweep
//  wrap        out  1   1-cycle pulse at each sweep restart/reversal (continuous)
// BEHAVIOUR
//  - Reset (async, clrn=0): state IDLE; phinc=0, busy=0, done=0, wrap=0; all shadow
//    regs and dwell counter cleared. Reset mid-sweep aborts instantly, no done.
//  - States: IDLE, RUN, DONE.
//  - IDLE: phinc=0. start=1 & abort=0 -> latch f_start/f_stop/f_step/dwell/continuous
//    into shadow regs; next cycle phinc=f_start, busy=1, cnt=dwell, state RUN.
//    Latency start->first phinc: 1 cycle. Inputs ignored after latch until IDLE.
//  - Direction: up if f_stop >= f_start else down; fixed at latch time.
//  - RUN: cnt decrements each cycle; at cnt==0 the value advances:
//    next = phinc +/- step computed W+1 bits; if next passes or equals f_stop
//    (overshoot or underflow past 0 / overflow past 2^W-1) -> phinc=f_stop (clamp).
//    Terminal when phinc already == f_stop at cnt==0.
//    cnt reloads to dwell on every value change.
//  - Terminal, continuous=0 -> DONE: done=1 one cycle, phinc=0, busy=0, then IDLE.
//  - Terminal, continuous=1 -> phinc=f_start, wrap=1 one cycle, cnt=dwell, stay RUN.
//  - f_start==f_stop: single value held dwell+1 cycles, then terminal.
//  - abort: highest priority, any state -> IDLE next cycle, phinc=0, busy=0, no
//    done/wrap. abort & start same cycle in IDLE: stays IDLE.
//  - start while busy: ignored. done and wrap never assert together.
// CONFIGURATION
//  SWEEP_BIDIR_EN defined: terminal reverses direction instead of restarting
//    (triangle). Single-shot: start->stop->start, done after return leg terminates at
//    f_start. Continuous: wrap pulses at every reversal (both ends); end values held
//    once (dwell+1 cycles), not repeated.
//  SWEEP_BIDIR_EN undefined: sawtooth behaviour as above; no reversal logic built.
// TESTING
//  1 f_start=10,f_stop=40,f_step=10,dwell=2,single -> phinc 10,20,30,40 each 3 cycles,
//    then done=1 1 cycle, phinc=0, busy=0.
//  2 f_start=10,f_stop=35,f_step=10,dwell=0 -> phinc 10,20,30,35 (clamp), done.
//  3 f_start=200,f_stop=180,f_step=7,dwell=0 -> 200,193,186,180; f_step=0 -> steps of 1.
//  4 f_start=250,f_stop=255,f_step=10,continuous=1,dwell=1 -> 250x2,255x2, wrap=1,
//    250x2...; no overflow past 255.
//  5 abort at 3rd value of test 1 -> phinc=0, busy=0 next cycle, no done; start+abort
//    in IDLE -> no sweep; clrn pulse mid-sweep -> all outputs 0 immediately.
//  6 SWEEP_BIDIR_EN, 10->30 step 10 dwell 0 single -> 10,20,30,20,10, done;
//    continuous -> wrap at 30 and at 10.

Source files
------------

// File: rtl/sweep_controller.sv
// rtl/sweep_controller.sv - frequency-sweep sequencer driving a DDS phase-accumulator increment
//
// Purpose: steps phinc from f_start to f_stop in f_step increments. Each value is
// held for dwell+1 cycles. The sweep runs single-shot or repeats continuously.
// Optional build macro SWEEP_BIDIR_EN: the sweep reverses at each end (triangle)
// instead of restarting (sawtooth).
//
// Ports:
//   clk         in   system clock, rising edge
//   clrn        in   asynchronous active-low reset
//   start       in   begin sweep (sampled in IDLE only)
//   abort       in   stop sweep immediately (highest priority)
//   continuous  in   1 = repeat sweep indefinitely
//   f_start     in   [W-1:0]  first increment
//   f_stop      in   [W-1:0]  final increment
//   f_step      in   [W-1:0]  step magnitude (0 treated as 1)
//   dwell       in   [DW-1:0] extra cycles per value
//   phinc       out  [W-1:0]  registered increment to accumulator
//   busy        out  sweep in progress
//   done        out  1-cycle pulse at end of single-shot sweep
//   wrap        out  1-cycle pulse at each restart/reversal in continuous mode
module sweep_controller #(
   parameter int W  = 8,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          clrn,
   input  logic          start,
   input  logic          abort,
   input  logic          continuous,
   input  logic [W-1:0]  f_start,
   input  logic [W-1:0]  f_stop,
   input  logic [W-1:0]  f_step,
   input  logic [DW-1:0] dwell,
   output logic [W-1:0]  phinc,
   output logic          busy,
   output logic          done,
   output logic          wrap
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t        state, state_n;
   logic [DW-1:0] cnt, cnt_n;
   logic [W-1:0]  phinc_n;
   logic          busy_n, done_n, wrap_n;
   logic          load;

   // Sweep parameters captured at start; live inputs are ignored until IDLE.
   logic [W-1:0]  s_start, s_stop, s_step;
   logic [DW-1:0] s_dwell;
   logic          s_cont;
   logic          s_up;

   // Endpoint and direction of the leg currently being swept.
   logic [W-1:0]  target;
   logic          up_now;

`ifdef SWEEP_BIDIR_EN
   // 0 = outbound leg (towards f_stop), 1 = return leg (towards f_start).
   logic          leg, leg_n;
`endif

   // Move one step from cur towards tgt. The sum is formed one bit wider, so a
   // wrap past 0 or past 2^W-1 is detected and clamped to the endpoint instead
   // of aliasing to a far-away frequency.
   function automatic logic [W-1:0] advance(input logic [W-1:0] cur,
                                            input logic [W-1:0] tgt,
                                            input logic [W-1:0] stp,
                                            input logic         up);
      logic [W:0] sum;
      if (up) begin
         sum = {1'b0, cur} + {1'b0, stp};
         advance = (sum >= {1'b0, tgt}) ? tgt : sum[W-1:0];
      end else begin
         sum = {1'b0, cur} - {1'b0, stp};
         advance = (sum[W] || (sum[W-1:0] <= tgt)) ? tgt : sum[W-1:0];
      end
   endfunction

   always_comb begin
      state_n = state;
      phinc_n = phinc;
      cnt_n   = cnt;
      done_n  = 1'b0;
      wrap_n  = 1'b0;
      load    = 1'b0;
`ifdef SWEEP_BIDIR_EN
      leg_n   = leg;
      target  = leg ? s_start : s_stop;
      up_now  = leg ? ~s_up : s_up;
`else
      target  = s_stop;
      up_now  = s_up;
`endif

      if (abort) begin
         state_n = ST_IDLE;
         phinc_n = '0;
         cnt_n   = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               phinc_n = '0;
               if (start) begin
                  load    = 1'b1;
                  state_n = ST_RUN;
                  phinc_n = f_start;
                  cnt_n   = dwell;
`ifdef SWEEP_BIDIR_EN
                  leg_n   = 1'b0;
`endif
               end
            end

            ST_RUN: begin
               if (cnt != '0) begin
                  cnt_n = cnt - DW'(1);
               end else if (phinc != target) begin
                  phinc_n = advance(phinc, target, s_step, up_now);
                  cnt_n   = s_dwell;
               end else begin
                  // Terminal: the endpoint has been held for its full dwell.
`ifdef SWEEP_BIDIR_EN
                  if (!leg && (s_start != s_stop)) begin
                     leg_n   = 1'b1;
                     phinc_n = advance(phinc, s_start, s_step, ~s_up);
                     cnt_n   = s_dwell;
                     wrap_n  = s_cont;
                  end else if (s_cont) begin
                     leg_n   = 1'b0;
                     wrap_n  = 1'b1;
                     cnt_n   = s_dwell;
                     // Degenerate start==stop sweep just re-holds the same value.
                     phinc_n = (s_start != s_stop) ?
                               advance(phinc, s_stop, s_step, s_up) : s_start;
                  end else begin
                     state_n = ST_DONE;
                     phinc_n = '0;
                     cnt_n   = '0;
                     done_n  = 1'b1;
                  end
`else
                  if (s_cont) begin
                     phinc_n = s_start;
                     wrap_n  = 1'b1;
                     cnt_n   = s_dwell;
                  end else begin
                     state_n = ST_DONE;
                     phinc_n = '0;
                     cnt_n   = '0;
                     done_n  = 1'b1;
                  end
`endif
               end
            end

            ST_DONE: begin
               state_n = ST_IDLE;
               phinc_n = '0;
               cnt_n   = '0;
            end

            default: begin
               state_n = ST_IDLE;
               phinc_n = '0;
               cnt_n   = '0;
            end
         endcase
      end

      busy_n = (state_n == ST_RUN);
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state   <= ST_IDLE;
         phinc   <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         wrap    <= 1'b0;
         s_start <= '0;
         s_stop  <= '0;
         s_step  <= '0;
         s_dwell <= '0;
         s_cont  <= 1'b0;
         s_up    <= 1'b0;
`ifdef SWEEP_BIDIR_EN
         leg     <= 1'b0;
`endif
      end else begin
         state <= state_n;
         phinc <= phinc_n;
         cnt   <= cnt_n;
         busy  <= busy_n;
         done  <= done_n;
         wrap  <= wrap_n;
`ifdef SWEEP_BIDIR_EN
         leg   <= leg_n;
`endif
         if (load) begin
            s_start <= f_start;
            s_stop  <= f_stop;
            s_step  <= (f_step == '0) ? W'(1) : f_step;
            s_dwell <= dwell;
            s_cont  <= continuous;
            s_up    <= (f_stop >= f_start);
         end
      end
   end

endmodule
